instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage of the single-issue MIPS-style core; sits directly upstream of the instruction memory. It owns the program counter and drives the memory's word-aligned byte address. It captures the returned instruction into an IF/ID pipeline register for decode, and handles stall and branch/jump redirect. It halts cleanly when the PC leaves the memory window or a redirect target is misaligned.

## Interface
- RESET_PC, 32'h0040_0000, first fetch address after reset
- MEM_HI, 32'h0040_0400, highest legal fetch byte address (inclusive); matches the memory array upper word 29'h0010_0100
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold PC and IF/ID contents (decode not ready)
- redirect  input  1  taken branch/jump resolved downstream
- redirect_pc  input  32  target byte address for redirect
- mem_instr  input  32  instruction word returned combinationally by memory for pc_out
- pc_out  output  32  current fetch byte address, to memory currPC
- ifid_instr  output  32  registered instruction
- ifid_pc4  output  32  registered fetch address + 4
- ifid_valid  output  1  IF/ID holds a real instruction
- halted  output  1  fetch stopped, sticky until reset
- fault  output  2  halt cause: 0 none, 1 out-of-range, 2 misaligned redirect

## Operation
- FSM states: BOOT, RUN, HALT. Reset → BOOT. BOOT → RUN after exactly one cycle, with no fetch captured in BOOT.
- RUN, per cycle, in priority order:
  - redirect: if redirect_pc[1:0] != 0 → HALT, fault=2. Otherwise PC ← redirect_pc and ifid_valid ← 0 (flush). This applies even when stall=1; redirect beats stall.
  - stall: PC, ifid_* all hold.
  - else: ifid_instr ← mem_instr, ifid_pc4 ← PC+4, ifid_valid ← 1, PC ← PC+4.
- Range check is made on the PC being fetched, not on the next PC. If PC < RESET_PC or PC > MEM_HI while in RUN and not stalled → HALT, fault=1, ifid_valid ← 0, PC holds.
- A redirect to an out-of-range but aligned target is accepted. It faults on the following cycle's fetch.
- HALT: all inputs ignored; PC, ifid_instr and ifid_pc4 hold; ifid_valid=0, halted=1. Exits only via rst.
- PC+4 arithmetic is 32-bit modulo. Wrap past 32'hFFFF_FFFC is unreachable because the range check fires first.

## Timing
- Reset values: pc_out=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, halted=0, fault=0.
- rst asserted mid-operation clears all state immediately (asynchronous). The first capture occurs on the second rising edge after rst deasserts (the BOOT cycle, then the first RUN edge).
- pc_out is a register output, stable for the whole cycle. Memory is combinational, so mem_instr is valid in the same cycle and is sampled at the next edge. Fetch latency is 1 cycle, PC → ifid.
- Redirect asserted in cycle N: pc_out=redirect_pc in cycle N+1, ifid_valid=0 in N+1, and the target instruction is in ifid in N+2. The redirect penalty is one bubble.
- Stall asserted in cycle N: the edge ending N does not update; mem_instr is re-read from the unchanged PC in N+1.
- Redirect and fault detection in the same cycle: redirect handling applies and the current PC's range fault is discarded.

## Configuration
- FETCH_STATS_EN defined: adds outputs stat_fetches[31:0] (cycles with a capture, ifid_valid←1), stat_stalls[31:0] (RUN cycles with stall=1 and no redirect) and stat_flushes[31:0] (accepted redirects).
  - All three reset to 0, saturate at 32'hFFFF_FFFF and freeze in HALT.
- FETCH_STATS_EN undefined: the ports and counters are absent; fetch behaviour is identical.

## Structure
- Shared package fetch_pkg: RESET_PC and MEM_HI constants, the fetch_state_t enum (BOOT, RUN, HALT) and the fetch_fault_t enum (NONE=0, RANGE=1, MISALIGN=2). The core decode stage imports the same constants.
- One sub-module, fetch_stats: the three saturating counters, instantiated only under FETCH_STATS_EN. Inputs are the capture, stall and flush strobes from the FSM.

## Test plan
- Reset release with memory words 0x20080001, 0x20090002 at 0x00400000/4: pc_out=0x00400000 in BOOT. The 2nd edge gives ifid_instr=0x20080001, ifid_pc4=0x00400004. The 3rd edge gives 0x20090002 with ifid_pc4=0x00400008.
- Stall held 3 cycles at PC 0x00400008: pc_out and ifid hold for those 3 cycles; the capture resumes with the 0x00400008 word; stat_stalls=3 with FETCH_STATS_EN.
- Redirect to 0x00400020 concurrent with stall=1: the next cycle has pc_out=0x00400020 and ifid_valid=0; the following cycle has ifid_pc4=0x00400024.
- Sequential run to 0x00400400, then 0x00400404: the 0x00400400 word is captured. Then halted=1, fault=1, ifid_valid=0 and pc_out holds at 0x00400404.
- Redirect to 0x00400022: immediate HALT with fault=2, and subsequent redirect/stall inputs are ignored.
- rst pulse mid-run at PC 0x00400010: all outputs return to reset values asynchronously, and fetch restarts at 0x00400000 after BOOT.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg -- constants and types shared by the instruction-fetch stage and
// the decode stage of the single-issue MIPS-style core.
//   RESET_PC      : first fetch byte address after reset
//   MEM_HI        : highest legal fetch byte address (inclusive)
//   fetch_state_t : fetch FSM states (BOOT, RUN, HALT)
//   fetch_fault_t : halt cause reported on the fault output
package fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] MEM_HI   = 32'h0040_0400;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    RANGE    = 2'd1,
    MISALIGN = 2'd2
  } fetch_fault_t;

  // True when a fetch byte address lies inside the instruction-memory window.
  function automatic logic in_window(input logic [31:0] pc);
    return (pc >= RESET_PC) && (pc <= MEM_HI);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if -- bundle between the fetch stage, the instruction memory
// and the decode/branch-resolution logic.
//   master (fetch stage): drives pc_out and the IF/ID register outputs,
//                         receives mem_instr, stall and redirect controls.
//   slave  (environment): the opposite directions.
interface instr_fetch_if;
  import fetch_pkg::*;

  logic [31:0]  pc_out;
  logic [31:0]  mem_instr;
  logic         stall;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc4;
  logic         ifid_valid;
  logic         halted;
  fetch_fault_t fault;

  modport master (
    input  mem_instr, stall, redirect, redirect_pc,
    output pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fault
  );

  modport slave (
    output mem_instr, stall, redirect, redirect_pc,
    input  pc_out, ifid_instr, ifid_pc4, ifid_valid, halted, fault
  );

endinterface

// File: rtl/fetch_stats.sv
// fetch_stats -- saturating event counters for the fetch stage.
//   clk, rst      : clock, asynchronous active-high reset
//   capture       : strobe, an instruction was captured into IF/ID
//   stall_evt     : strobe, a RUN cycle stalled without redirect
//   flush         : strobe, a redirect was accepted
//   fetches, stalls, flushes : counters, saturate at all-ones
module fetch_stats #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              stall_evt,
  input  logic              flush,
  output logic [DATA_W-1:0] fetches,
  output logic [DATA_W-1:0] stalls,
  output logic [DATA_W-1:0] flushes
);

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetches <= '0;
      stalls  <= '0;
      flushes <= '0;
    end else begin
      if (capture)   fetches <= sat_inc(fetches);
      if (stall_evt) stalls  <= sat_inc(stalls);
      if (flush)     flushes <= sat_inc(flushes);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch -- instruction-fetch stage. Owns the PC, drives the memory
// byte address, captures the returned word into the IF/ID register, and
// handles stall, branch/jump redirect and halting on bad addresses.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : instr_fetch_if.master (pc_out, mem_instr, stall, redirect,
//              redirect_pc, ifid_instr, ifid_pc4, ifid_valid, halted, fault)
// Optional macro FETCH_STATS_EN adds stat_fetches, stat_stalls and
// stat_flushes (32-bit saturating counters).
module instr_fetch
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  instr_fetch_if.master      bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetches,
  output logic [31:0]        stat_stalls,
  output logic [31:0]        stat_flushes
`endif
);

  fetch_state_t state;
  logic [31:0]  pc_p0;
  logic [31:0]  instr_p1;
  logic [31:0]  pc4_p1;
  logic         vld_p1;
  logic         halted_q;
  fetch_fault_t fault_q;

  // Mutually exclusive RUN-cycle events. Redirect outranks stall, and stall
  // outranks the range check, so a PC that is about to be replaced or held
  // never raises a range fault.
  logic capture, flush, misalign, range_err;

  always_comb begin
    capture   = 1'b0;
    flush     = 1'b0;
    misalign  = 1'b0;
    range_err = 1'b0;
    if (state == RUN) begin
      if (bus.redirect) begin
        if (bus.redirect_pc[1:0] != 2'b00) misalign = 1'b1;
        else                               flush    = 1'b1;
      end else if (!bus.stall) begin
        if (in_window(pc_p0)) capture   = 1'b1;
        else                  range_err = 1'b1;
      end
    end
  end

  // p0 -> p1: PC register feeds memory; word is captured into IF/ID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc_p0    <= RESET_PC;
      instr_p1 <= '0;
      pc4_p1   <= '0;
      vld_p1   <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= NONE;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (misalign || range_err) begin
            state    <= HALT;
            halted_q <= 1'b1;
            vld_p1   <= 1'b0;
            fault_q  <= misalign ? MISALIGN : RANGE;
          end else if (flush) begin
            // Accepted even when out of range; the next fetch checks it.
            pc_p0  <= bus.redirect_pc;
            vld_p1 <= 1'b0;
          end else if (capture) begin
            instr_p1 <= bus.mem_instr;
            pc4_p1   <= pc_p0 + 32'd4;
            vld_p1   <= 1'b1;
            pc_p0    <= pc_p0 + 32'd4;
          end
        end
        HALT: vld_p1 <= 1'b0;
        default: state <= HALT;
      endcase
    end
  end

  assign bus.pc_out     = pc_p0;
  assign bus.ifid_instr = instr_p1;
  assign bus.ifid_pc4   = pc4_p1;
  assign bus.ifid_valid = vld_p1;
  assign bus.halted     = halted_q;
  assign bus.fault      = fault_q;

`ifdef FETCH_STATS_EN
  logic stall_evt;
  assign stall_evt = (state == RUN) && bus.stall && !bus.redirect;

  fetch_stats #(.DATA_W(32)) u_stats (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .stall_evt (stall_evt),
    .flush     (flush),
    .fetches   (stat_fetches),
    .stalls    (stat_stalls),
    .flushes   (stat_flushes)
  );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch -- self-checking bench for instr_fetch with a behavioural
// memory and fetch model. Compile with FETCH_STATS_EN to also check stats.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if bus();

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetches, stat_stalls, stat_flushes;
`endif

  instr_fetch dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetches (stat_fetches),
    .stat_stalls  (stat_stalls),
    .stat_flushes (stat_flushes)
`endif
  );

  // Instruction memory: 257 words covering RESET_PC..MEM_HI.
  logic [31:0] mem [0:256];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    if (a >= RESET_PC && a <= MEM_HI) begin
      idx = (a - RESET_PC) >> 2;
      return mem[idx[8:0]];
    end
    return {a[15:0], 16'hBAD0};
  endfunction

  assign bus.mem_instr = mem_word(bus.pc_out);

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halt, m_boot;
  logic [1:0]  m_fault;
  int unsigned m_fetches, m_stalls, m_flushes;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [99:0] obs();
    return {bus.pc_out, bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid, bus.halted, 2'(bus.fault)};
  endfunction

  function automatic logic [99:0] mdl();
    return {m_pc, m_instr, m_pc4, m_valid, m_halt, m_fault};
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0;
    m_halt = 0; m_boot = 1; m_fault = 0;
    m_fetches = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // Advance the model by one clock using the current inputs, then the DUT.
  task automatic step();
    if (m_halt) begin
      m_valid = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (bus.redirect) begin
      if (bus.redirect_pc % 4 != 0) begin
        m_halt = 1; m_fault = 2; m_valid = 0;
      end else begin
        m_pc = bus.redirect_pc; m_valid = 0; m_flushes++;
      end
    end else if (bus.stall) begin
      m_stalls++;
    end else if (m_pc < RESET_PC || m_pc > MEM_HI) begin
      m_halt = 1; m_fault = 1; m_valid = 0;
    end else begin
      m_instr = mem_word(m_pc); m_pc4 = m_pc + 4; m_valid = 1;
      m_pc = m_pc + 4; m_fetches++;
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0;
    rst = 1;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0;
    rst = 1;
    model_reset();
    #2;
    n_tests++;
    if (obs() !== {RESET_PC, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", obs(), {RESET_PC, 64'h0, 4'h0});
    end
    @(negedge clk);
    rst = 0;
    n_tests++;
    if (bus.pc_out !== 32'h0040_0000 || bus.ifid_valid !== 1'b0) begin
      n_fail++; $display("FAIL boot_pc: got pc %h valid %b expected 00400000 0", bus.pc_out, bus.ifid_valid);
    end
    step();
    n_tests++;
    if (bus.ifid_valid !== 1'b0 || bus.pc_out !== 32'h0040_0000) begin
      n_fail++; $display("FAIL boot_no_capture: got pc %h valid %b expected 00400000 0", bus.pc_out, bus.ifid_valid);
    end
    step();
    n_tests++;
    if (bus.ifid_instr !== 32'h2008_0001 || bus.ifid_pc4 !== 32'h0040_0004 || bus.ifid_valid !== 1'b1) begin
      n_fail++; $display("FAIL first_fetch: got %h/%h/%b expected 20080001/00400004/1", bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid);
    end
    step();
    n_tests++;
    if (bus.ifid_instr !== 32'h2009_0002 || bus.ifid_pc4 !== 32'h0040_0008 || obs() !== mdl()) begin
      n_fail++; $display("FAIL second_fetch: got %h expected %h", obs(), mdl());
    end
  endtask

  task automatic test_stall();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (bus.pc_out !== 32'h0040_0008 || bus.ifid_instr !== 32'h2009_0002 ||
          bus.ifid_pc4 !== 32'h0040_0008 || bus.ifid_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h expected pc 00400008 instr 20090002", i, obs());
      end
    end
    bus.stall = 0;
    step();
    n_tests++;
    if (bus.ifid_instr !== mem[2] || bus.ifid_pc4 !== 32'h0040_000C || bus.pc_out !== 32'h0040_000C) begin
      n_fail++; $display("FAIL stall_resume: got %h expected instr %h pc4 0040000c", obs(), mem[2]);
    end
`ifdef FETCH_STATS_EN
    n_tests++;
    if (stat_stalls !== 32'd3 || stat_fetches !== 32'd3) begin
      n_fail++; $display("FAIL stat_stalls: got %0d/%0d expected 3/3", stat_stalls, stat_fetches);
    end
`endif
  endtask

  task automatic test_redirect_stall();
    bus.stall = 1; bus.redirect = 1; bus.redirect_pc = 32'h0040_0020;
    step();
    bus.stall = 0; bus.redirect = 0;
    n_tests++;
    if (bus.pc_out !== 32'h0040_0020 || bus.ifid_valid !== 1'b0 || bus.halted !== 1'b0) begin
      n_fail++; $display("FAIL redirect_flush: got pc %h valid %b expected 00400020 0", bus.pc_out, bus.ifid_valid);
    end
    step();
    n_tests++;
    if (bus.ifid_pc4 !== 32'h0040_0024 || bus.ifid_instr !== mem[8] || bus.ifid_valid !== 1'b1) begin
      n_fail++; $display("FAIL redirect_target: got %h expected pc4 00400024 instr %h", obs(), mem[8]);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      bus.stall       = ($urandom_range(0, 3) == 0);
      bus.redirect    = ($urandom_range(0, 7) == 0);
      bus.redirect_pc = RESET_PC + 32'($urandom_range(0, 240)) * 4;
      step();
      n_tests++;
      if (obs() !== mdl()) begin
        n_fail++; errs++;
        if (errs < 5) $display("FAIL random[%0d]: got %h expected %h", i, obs(), mdl());
      end
    end
    bus.stall = 0; bus.redirect = 0;
`ifdef FETCH_STATS_EN
    n_tests++;
    if ({stat_fetches, stat_stalls, stat_flushes} !== {m_fetches, m_stalls, m_flushes}) begin
      n_fail++; $display("FAIL random_stats: got %0d/%0d/%0d expected %0d/%0d/%0d",
        stat_fetches, stat_stalls, stat_flushes, m_fetches, m_stalls, m_flushes);
    end
`endif
  endtask

  task automatic test_range_end();
    reset_dut();
    step();
    bus.redirect = 1; bus.redirect_pc = 32'h0040_03F8;
    step();
    bus.redirect = 0;
    repeat (3) step();
    n_tests++;
    if (bus.ifid_instr !== mem[256] || bus.ifid_pc4 !== 32'h0040_0404 || bus.ifid_valid !== 1'b1 || bus.halted !== 1'b0) begin
      n_fail++; $display("FAIL last_word: got %h expected instr %h pc4 00400404", obs(), mem[256]);
    end
    step();
    n_tests++;
    if (bus.halted !== 1'b1 || bus.fault !== RANGE || bus.ifid_valid !== 1'b0 || bus.pc_out !== 32'h0040_0404) begin
      n_fail++; $display("FAIL range_halt: got %h expected halted fault=1 pc 00400404", obs());
    end
    for (int i = 0; i < 4; i++) begin
      bus.stall = 1'($urandom); bus.redirect = 1'($urandom); bus.redirect_pc = RESET_PC;
      step();
    end
    bus.stall = 0; bus.redirect = 0;
    n_tests++;
    if (obs() !== mdl() || bus.pc_out !== 32'h0040_0404) begin
      n_fail++; $display("FAIL range_sticky: got %h expected %h", obs(), mdl());
    end
  endtask

  task automatic test_misalign();
    reset_dut();
    step(); step();
    bus.redirect = 1; bus.redirect_pc = 32'h0040_0022;
    step();
    n_tests++;
    if (bus.halted !== 1'b1 || bus.fault !== MISALIGN || bus.ifid_valid !== 1'b0 ||
        bus.pc_out !== 32'h0040_0004 || bus.ifid_instr !== mem[0]) begin
      n_fail++; $display("FAIL misalign_halt: got %h expected halted fault=2 pc 00400004", obs());
    end
    for (int i = 0; i < 6; i++) begin
      bus.stall = 1'($urandom); bus.redirect = 1'($urandom);
      bus.redirect_pc = RESET_PC + 32'($urandom_range(0, 100)) * 4;
      step();
      n_tests++;
      if (obs() !== mdl()) begin
        n_fail++; $display("FAIL misalign_sticky[%0d]: got %h expected %h", i, obs(), mdl());
      end
    end
    bus.stall = 0; bus.redirect = 0;
  endtask

  task automatic test_redirect_range();
    reset_dut();
    step();
    bus.redirect = 1; bus.redirect_pc = 32'h0050_0000;
    step();
    n_tests++;
    if (bus.pc_out !== 32'h0050_0000 || bus.halted !== 1'b0) begin
      n_fail++; $display("FAIL oor_accept: got pc %h halted %b expected 00500000 0", bus.pc_out, bus.halted);
    end
    // Redirect in the same cycle as the range fault: the fault is discarded.
    bus.redirect_pc = 32'h0040_0040;
    step();
    bus.redirect = 0;
    n_tests++;
    if (bus.pc_out !== 32'h0040_0040 || bus.halted !== 1'b0 || bus.fault !== NONE) begin
      n_fail++; $display("FAIL redirect_beats_fault: got %h expected pc 00400040 no fault", obs());
    end
    step();
    n_tests++;
    if (bus.ifid_pc4 !== 32'h0040_0044 || bus.ifid_instr !== mem[16]) begin
      n_fail++; $display("FAIL post_redirect: got %h expected pc4 00400044", obs());
    end
    bus.redirect = 1; bus.redirect_pc = 32'h0050_0000;
    step();
    bus.redirect = 0;
    step();
    n_tests++;
    if (bus.halted !== 1'b1 || bus.fault !== RANGE || bus.pc_out !== 32'h0050_0000 || obs() !== mdl()) begin
      n_fail++; $display("FAIL oor_fault: got %h expected %h", obs(), mdl());
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    repeat (5) step();
    n_tests++;
    if (bus.pc_out !== 32'h0040_0010) begin
      n_fail++; $display("FAIL pre_reset_pc: got %h expected 00400010", bus.pc_out);
    end
    @(negedge clk);
    #2 rst = 1;
    #1;
    n_tests++;
    if (obs() !== {RESET_PC, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL async_clear: got %h expected %h", obs(), {RESET_PC, 68'h0});
    end
`ifdef FETCH_STATS_EN
    n_tests++;
    if ({stat_fetches, stat_stalls, stat_flushes} !== 96'h0) begin
      n_fail++; $display("FAIL stats_reset: got %0d/%0d/%0d expected 0/0/0", stat_fetches, stat_stalls, stat_flushes);
    end
`endif
    model_reset();
    @(negedge clk);
    rst = 0;
    step();
    n_tests++;
    if (bus.ifid_valid !== 1'b0 || bus.pc_out !== RESET_PC) begin
      n_fail++; $display("FAIL restart_boot: got %h expected pc 00400000 invalid", obs());
    end
    step();
    n_tests++;
    if (bus.ifid_instr !== 32'h2008_0001 || bus.ifid_pc4 !== 32'h0040_0004 || obs() !== mdl()) begin
      n_fail++; $display("FAIL restart_fetch: got %h expected %h", obs(), mdl());
    end
  endtask

  initial begin
    for (int i = 0; i <= 256; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    test_reset();
    test_stall();
    test_redirect_stall();
    test_random();
    test_range_end();
    test_misalign();
    test_redirect_range();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
